// File: rtl/scan_sequencer_if.sv
// Transmitter-side link of the scan sequencer: steering angle, focal radius,
// the one-cycle initiate pulse and the Transmitter's done strobe.
interface scan_sequencer_if #(
  parameter int ANGLE_DW = 8,
  parameter int DW_INPUT = 8
);
  logic [ANGLE_DW-1:0] angle;
  logic [DW_INPUT-1:0] r_0;
  logic                initiate;
  logic                tx_done;

  modport master (
    output angle,
    output r_0,
    output initiate,
    input  tx_done
  );

  modport slave (
    input  angle,
    input  r_0,
    input  initiate,
    output tx_done
  );
endinterface

// File: rtl/scan_sequencer.sv
// Frame sequencer for the Transmitter: sweeps the steering angle line by line,
// fires one initiate per line, waits for done, dwells, then advances.
module scan_sequencer #(
  parameter int ANGLE_DW = 8,
  parameter int DW_INPUT = 8,
  parameter int DWELL_DW = 16,
  parameter int TIMEOUT  = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [ANGLE_DW-1:0] angle_start,
  input  logic [ANGLE_DW-1:0] angle_end,
  input  logic [ANGLE_DW-1:0] angle_step,
  input  logic [DW_INPUT-1:0] r_0_in,
  input  logic [DWELL_DW-1:0] dwell_cycles,
  scan_sequencer_if.master    tx,
  output logic [7:0]          line_idx,
  output logic                busy,
  output logic                frame_done,
  output logic                timeout_err,
  output logic                cfg_err
);

  localparam int TO_W  = $clog2(TIMEOUT);
  localparam int CNT_W = (DWELL_DW > TO_W) ? DWELL_DW : TO_W;

  typedef enum logic [2:0] {
    IDLE,
    FIRE,
    WAIT_DONE,
    DWELL,
    ADVANCE,
    FINISH
  } state_t;

  state_t              state_q, state_d;
  logic [ANGLE_DW-1:0] angle_q, angle_d;
  logic [ANGLE_DW-1:0] end_q, end_d;
  logic [ANGLE_DW-1:0] step_q, step_d;
  logic [DW_INPUT-1:0] r_0_q, r_0_d;
  logic [DWELL_DW-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          line_q, line_d;
  logic                initiate_q, initiate_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
  logic                timeout_q, timeout_d;
  logic                cfg_err_q, cfg_err_d;
  logic [ANGLE_DW:0]   next_angle;

  always_comb begin
    state_d      = state_q;
    angle_d      = angle_q;
    end_d        = end_q;
    step_d       = step_q;
    r_0_d        = r_0_q;
    dwell_d      = dwell_q;
    cnt_d        = cnt_q;
    line_d       = line_q;
    timeout_d    = timeout_q;
    cfg_err_d    = 1'b0;
    // One extra bit so an overflowing step is seen as past angle_end, not wrapped.
    next_angle   = {1'b0, angle_q} + {1'b0, step_q};

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (angle_start <= angle_end) begin
              angle_d   = angle_start;
              end_d     = angle_end;
              step_d    = angle_step;
              r_0_d     = r_0_in;
              dwell_d   = dwell_cycles;
              line_d    = '0;
              timeout_d = 1'b0;
              state_d   = FIRE;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        FIRE: begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx.tx_done) begin
            if (dwell_q == '0) begin
              state_d = ADVANCE;
            end else begin
              cnt_d   = CNT_W'(dwell_q);
              state_d = DWELL;
            end
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DWELL: begin
          // Counter holds the cycles still to spend here, including this one.
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ADVANCE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ADVANCE: begin
          if ((step_q == '0) || (next_angle > {1'b0, end_q})) begin
            state_d = FINISH;
          end else begin
            angle_d = next_angle[ANGLE_DW-1:0];
            line_d  = line_q + 1'b1;
            state_d = FIRE;
          end
        end
        FINISH: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Outputs registered from the next state so they line up with the state itself.
    initiate_d   = (state_d == FIRE);
    frame_done_d = (state_d == FINISH);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      angle_q      <= '0;
      end_q        <= '0;
      step_q       <= '0;
      r_0_q        <= '0;
      dwell_q      <= '0;
      cnt_q        <= '0;
      line_q       <= '0;
      initiate_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      timeout_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      angle_q      <= angle_d;
      end_q        <= end_d;
      step_q       <= step_d;
      r_0_q        <= r_0_d;
      dwell_q      <= dwell_d;
      cnt_q        <= cnt_d;
      line_q       <= line_d;
      initiate_q   <= initiate_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      timeout_q    <= timeout_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign tx.angle    = angle_q;
  assign tx.r_0      = r_0_q;
  assign tx.initiate = initiate_q;
  assign line_idx    = line_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign timeout_err = timeout_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
- Upstream controller for the Transmitter stage.
- Sweeps the steering angle across a frame of scanlines and drives the Transmitter's angle, r_0 and initiate inputs.
- For each scanline: fires one initiate, waits for the Transmitter's done, holds a programmable listen/dwell interval, then advances to the next angle.
- Reports frame completion, Transmitter timeout and configuration errors.

Parameters:
- ANGLE_DW, 8, width of angle fields and of the angle output.
- DW_INPUT, 8, width of the r_0 field.
- DWELL_DW, 16, width of the dwell_cycles input.
- TIMEOUT, 4096, maximum cycles spent in WAIT_DONE before timeout_err is raised.

Ports:
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-high
- start  in  1  begin a frame; sampled only in IDLE
- abort  in  1  cancel the frame; returns to IDLE
- angle_start  in  ANGLE_DW  first scanline angle (unsigned)
- angle_end  in  ANGLE_DW  last allowed angle, inclusive
- angle_step  in  ANGLE_DW  angle increment; 0 means a single scanline
- r_0_in  in  DW_INPUT  focal start radius applied to every line
- dwell_cycles  in  DWELL_DW  listen interval after each done
- tx_done  in  1  Transmitter done (scanline transmitted)
- angle  out  ANGLE_DW  current angle to the Transmitter
- r_0  out  DW_INPUT  latched r_0 to the Transmitter
- initiate  out  1  one-cycle fire pulse to the Transmitter
- line_idx  out  8  index of the current scanline, starting at 0
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse at normal frame end
- timeout_err  out  1  sticky; cleared by rst or an accepted start
- cfg_err  out  1  one-cycle pulse on rejected configuration

Behaviour:
Reset:
- rst forces IDLE.
- All outputs are 0, including angle, r_0, line_idx and both error flags.
- rst overrides abort and start in the same cycle.

States: IDLE, FIRE, WAIT_DONE, DWELL, ADVANCE, FINISH. All outputs are registered or Moore outputs.

IDLE:
- start=1 with angle_start<=angle_end:
  - latch all config inputs into shadow registers (later input changes are ignored for the rest of the frame);
  - set angle=angle_start, r_0=r_0_in, line_idx=0;
  - clear timeout_err;
  - go to FIRE.
- start=1 with angle_start>angle_end: pulse cfg_err the next cycle, stay in IDLE, no initiate.

FIRE:
- initiate=1 for exactly this cycle.
- Next state is WAIT_DONE; the timeout counter is reset to 0.

WAIT_DONE:
- tx_done=1 and dwell==0: go to ADVANCE.
- tx_done=1 and dwell>0: go to DWELL, load the counter with dwell.
- Counter reaches TIMEOUT-1 without tx_done: set timeout_err=1 and go to IDLE; no frame_done.
- tx_done is ignored in every other state, including the FIRE cycle.

DWELL:
- Lasts exactly dwell_cycles cycles, then goes to ADVANCE.

ADVANCE (one cycle):
- Compute next = angle + step at ANGLE_DW+1 bits.
- step==0, or next > angle_end: go to FINISH.
- Otherwise: angle<=next[ANGLE_DW-1:0], line_idx+=1 (wraps at 255, no other effect), go to FIRE.

FINISH:
- frame_done=1 for this cycle, then IDLE.

Output stability:
- angle and r_0 stay stable from FIRE through ADVANCE and hold their last values in IDLE.

abort:
- abort=1 in any non-IDLE state goes to IDLE next cycle.
- No frame_done; initiate is forced to 0 in that cycle.
- timeout_err is unchanged.
- abort in IDLE has no effect.

Other rules:
- start while busy is ignored.
- start and abort high together in IDLE: start wins.

Timing:
- start sampled at edge k: initiate is high in cycle k+1.
- tx_done high in cycle D: FIRE in D+dwell+2 (or FINISH in D+dwell+2); busy low at D+dwell+3.
- With dwell==0 the DWELL state is skipped, so the formula holds with dwell=0.

Test Plan:
- Single line: angle_start=60, angle_end=60, step=0, r_0_in=10, dwell=5, tx_done 20 cycles after initiate -> one initiate, angle=60, r_0=10, line_idx=0; frame_done 7 cycles after tx_done; busy low one cycle later.
- Sweep: start=30, end=60, step=10, dwell=0 -> four initiates with angle 30/40/50/60, line_idx 0..3, then frame_done; re-driving inputs mid-frame has no effect.
- Overflow: start=250, end=255, step=10 -> exactly one line at 250 (next=260 > 255), then frame_done; no wrap to angle 4.
- Timeout: no tx_done after initiate -> timeout_err=1 after 4096 cycles, busy=0, frame_done never asserted; next accepted start clears timeout_err.
- Abort and start rules:
  - abort during DWELL of line 1 of a 30..60 sweep -> IDLE next cycle, no further initiate, no frame_done.
  - start during busy is ignored.
  - rst mid-frame zeroes all outputs.
- Config error: angle_start=90, angle_end=60 -> cfg_err pulses one cycle, no initiate, busy stays 0; tx_done pulsed in IDLE or FIRE is ignored.
